// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST controller.
// Holds the FSM state encoding and the test-pattern generator.
package ram_bist_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [31:0] exp_data(
    input logic [31:0] seed,
    input logic [31:0] addr,
    input logic        invert
  );
    logic [31:0] s;
    s = seed + addr;
    return invert ? ~s : s;
  endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// Single-port RAM bus driven by the BIST controller.
// The master drives wr/addr/wdata; the RAM side returns rdata.
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/ram_bist_ctrl_cmp_pipe.sv
// Read-latency matched compare pipe with saturating error counter
// and first-failing-address capture.
module bist_cmp_pipe
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_v_i,
  input  logic [ADDR_W-1:0] push_a_i,
  input  logic [DATA_W-1:0] push_e_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] ffa_o,
  output logic              err_zero_o
);

  logic [RD_LAT-1:0] v_q;
  logic [ADDR_W-1:0] a_q [RD_LAT];
  logic [DATA_W-1:0] e_q [RD_LAT];
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] ffa_q;
  logic              mism;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q[0] <= push_v_i;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    a_q[0] <= push_a_i;
    e_q[0] <= push_e_i;
    for (int i = 1; i < RD_LAT; i++) begin
      a_q[i] <= a_q[i-1];
      e_q[i] <= e_q[i-1];
    end
  end

  assign mism = v_q[RD_LAT-1] &&
                (rdata_i != e_q[RD_LAT-1]);

  // err_q never returns to zero once bumped, so zero means "no miss yet"
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      err_q <= '0;
      ffa_q <= '0;
    end else if (mism) begin
      if (err_q != '1) begin
        err_q <= err_q + ERR_W'(1);
      end
      if (err_q == '0) begin
        ffa_q <= a_q[RD_LAT-1];
      end
    end
  end

  assign err_count_o = err_q;
  assign ffa_o       = ffa_q;
  assign err_zero_o  = (err_q == '0) && !mism;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Built-in self-test master for a single-port RAM: write, read back, compare.
// Define BIST_INVERSE_PASS_EN to add a second pass with inverted patterns.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  ram_bist_ctrl_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

`ifdef BIST_INVERSE_PASS_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam int CNT_W = 3;
  localparam logic [ADDR_W-1:0] AMAX = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              inv_q;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic              clr;
  logic              push_v;
  logic [DATA_W-1:0] push_e;
  logic [DATA_W-1:0] nxt_e;
  logic              err_zero;

  assign clr    = (state_q == IDLE) && start;
  assign push_v = (state_q == READ);
  assign push_e = DATA_W'(exp_data(32'(seed_q),
                                   32'(addr_q), inv_q));
  assign nxt_e  = DATA_W'(exp_data(32'(seed_q),
                                   32'(addr_q) + 32'd1,
                                   inv_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      wr_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wr_q   <= 1'b1;
          addr_q <= '0;
          if (start) begin
            state_q <= WRITE;
            seed_q  <= seed;
            inv_q   <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            wr_q    <= 1'b0;
            wdata_q <= DATA_W'(exp_data(32'(seed),
                                        32'd0, 1'b0));
          end
        end
        WRITE: begin
          if (addr_q == AMAX) begin
            state_q <= READ;
            wr_q    <= 1'b1;
            addr_q  <= '0;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            wdata_q <= nxt_e;
          end
        end
        READ: begin
          addr_q <= addr_q + ADDR_W'(1);
          if (addr_q == AMAX) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(RD_LAT - 1)) begin
            if (INV_EN && !inv_q) begin
              state_q <= WRITE;
              inv_q   <= 1'b1;
              wr_q    <= 1'b0;
              addr_q  <= '0;
              wdata_q <= DATA_W'(exp_data(32'(seed_q),
                                          32'd0, 1'b1));
            end else begin
              // pass must fold in the compare landing this cycle
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= err_zero;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  bist_cmp_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .push_v_i    (push_v),
    .push_a_i    (addr_q),
    .push_e_i    (push_e),
    .rdata_i     (mem.mem_rdata),
    .err_count_o (err_count),
    .ffa_o       (first_fail_addr),
    .err_zero_o  (err_zero)
  );

  assign mem.mem_wr    = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: two instances (RD_LAT 1 and 3)
// each in front of a small behavioural RAM with injectable faults.
module tb_ram_bist_ctrl;
  import ram_bist_pkg::*;

`ifdef BIST_INVERSE_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam int LAT_A = NP * (16 + 1) + 1;
  localparam int LAT_B = NP * (16 + 3) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_a = 1'b0;
  logic [7:0] seed_a = '0;
  logic       busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [2:0] ffa_a;

  logic       start_b = 1'b0;
  logic [7:0] seed_b = '0;
  logic       busy_b, done_b, pass_b;
  logic [7:0] err_b;
  logic [2:0] ffa_b;

  int n_tests = 0;
  int n_fail  = 0;
  int mode_a  = 0;

  ram_bist_ctrl_if #(.ADDR_W(3), .DATA_W(8)) ifa ();
  ram_bist_ctrl_if #(.ADDR_W(3), .DATA_W(8)) ifb ();

  ram_bist_ctrl #(.ADDR_W(3), .DATA_W(8), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed_a),
    .mem(ifa), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_addr(ffa_a)
  );

  ram_bist_ctrl #(.ADDR_W(3), .DATA_W(8), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed_b),
    .mem(ifb), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_addr(ffa_b)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [8];
  logic [7:0] rp_a;
  logic [7:0] mem_b [8];
  logic [7:0] rp_b [3];

  function automatic logic [7:0] fault(input logic [7:0] d,
                                       input logic [2:0] a);
    if (mode_a == 1 && a == 3'd3) return 8'h00;
    if (mode_a == 2) return d | 8'h01;
    return d;
  endfunction

  always @(posedge clk) begin
    if (!ifa.mem_wr) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    rp_a <= fault(mem_a[ifa.mem_addr], ifa.mem_addr);
    if (!ifb.mem_wr) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
    rp_b[0] <= mem_b[ifb.mem_addr];
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end

  assign ifa.mem_rdata = rp_a;
  assign ifb.mem_rdata = rp_b[2];

  task automatic wait_done_a(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start_a = 1'b0;
    end while (!done_a && k < 100);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy_a !== 1'b0) begin n_fail++;
      $display("FAIL rst_busy got %0b want 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++;
      $display("FAIL rst_done got %0b want 0", done_a); end
    n_tests++; if (pass_a !== 1'b0) begin n_fail++;
      $display("FAIL rst_pass got %0b want 0", pass_a); end
    n_tests++; if (err_a !== 8'd0) begin n_fail++;
      $display("FAIL rst_err got %0d want 0", err_a); end
    n_tests++; if (ffa_a !== 3'd0) begin n_fail++;
      $display("FAIL rst_ffa got %0d want 0", ffa_a); end
    n_tests++; if (ifa.mem_wr !== 1'b1) begin n_fail++;
      $display("FAIL rst_wr got %0b want 1", ifa.mem_wr); end
    n_tests++; if (ifa.mem_addr !== 3'd0) begin n_fail++;
      $display("FAIL rst_addr got %0d want 0", ifa.mem_addr); end
    n_tests++; if (ifa.mem_wdata !== 8'd0) begin n_fail++;
      $display("FAIL rst_wdata got %0h want 0", ifa.mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal;
    int k;
    logic [7:0] e;
    bit got;
    mode_a = 0; seed_a = 8'h0A; start_a = 1'b1;
    k = 0; got = 0;
    while (k < 100 && !got) begin
      @(negedge clk);
      k++;
      start_a = 1'b0;
      if (k == 1) begin
        n_tests++; if (busy_a !== 1'b1) begin n_fail++;
          $display("FAIL ideal_busy got %0b want 1", busy_a); end
      end
      if (k <= 8) begin
        e = 8'(10 + k - 1);
        n_tests++; if (ifa.mem_wr !== 1'b0) begin n_fail++;
          $display("FAIL ideal_wr k=%0d got %0b want 0", k, ifa.mem_wr); end
        n_tests++; if (ifa.mem_addr !== 3'(k - 1)) begin n_fail++;
          $display("FAIL ideal_addr k=%0d got %0d want %0d",
                   k, ifa.mem_addr, k - 1); end
        n_tests++; if (ifa.mem_wdata !== e) begin n_fail++;
          $display("FAIL ideal_wdata k=%0d got %0h want %0h",
                   k, ifa.mem_wdata, e); end
      end
      if (done_a) got = 1;
    end
    n_tests++; if (k !== LAT_A) begin n_fail++;
      $display("FAIL ideal_lat got %0d want %0d", k, LAT_A); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++;
      $display("FAIL ideal_pass got %0b want 1", pass_a); end
    n_tests++; if (err_a !== 8'd0) begin n_fail++;
      $display("FAIL ideal_err got %0d want 0", err_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++;
      $display("FAIL ideal_busy_done got %0b want 0", busy_a); end
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0) begin n_fail++;
      $display("FAIL ideal_pulse got %0b want 0", done_a); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++;
      $display("FAIL ideal_pass_hold got %0b want 1", pass_a); end
  endtask

  task automatic test_corrupt;
    int k;
    mode_a = 1; seed_a = 8'h0A; start_a = 1'b1;
    wait_done_a(k);
    n_tests++; if (k !== LAT_A) begin n_fail++;
      $display("FAIL corr_lat got %0d want %0d", k, LAT_A); end
    n_tests++; if (pass_a !== 1'b0) begin n_fail++;
      $display("FAIL corr_pass got %0b want 0", pass_a); end
    n_tests++; if (err_a !== 8'(NP)) begin n_fail++;
      $display("FAIL corr_err got %0d want %0d", err_a, NP); end
    n_tests++; if (ffa_a !== 3'd3) begin n_fail++;
      $display("FAIL corr_ffa got %0d want 3", ffa_a); end
    @(negedge clk);
  endtask

  task automatic test_stuck;
    int k;
    mode_a = 2; seed_a = 8'h00; start_a = 1'b1;
    wait_done_a(k);
    n_tests++; if (pass_a !== 1'b0) begin n_fail++;
      $display("FAIL stuck_pass got %0b want 0", pass_a); end
    n_tests++; if (err_a !== 8'(4 * NP)) begin n_fail++;
      $display("FAIL stuck_err got %0d want %0d", err_a, 4 * NP); end
    n_tests++; if (ffa_a !== 3'd0) begin n_fail++;
      $display("FAIL stuck_ffa got %0d want 0", ffa_a); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int k, nd, kd;
    mode_a = 0; seed_a = 8'h33; start_a = 1'b1;
    nd = 0; kd = 0;
    for (k = 1; k <= LAT_A + 5; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a) begin nd++; kd = k; end
      if (k == 5 || done_a) start_a = 1'b1;
    end
    n_tests++; if (nd !== 1) begin n_fail++;
      $display("FAIL b2b_ndone got %0d want 1", nd); end
    n_tests++; if (kd !== LAT_A) begin n_fail++;
      $display("FAIL b2b_lat got %0d want %0d", kd, LAT_A); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++;
      $display("FAIL b2b_pass got %0b want 1", pass_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle got %0b want 0", busy_a); end
  endtask

  task automatic test_rst_mid;
    int k, nd;
    mode_a = 1; seed_a = 8'h0A; start_a = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy_a !== 1'b0) begin n_fail++;
      $display("FAIL rmid_busy got %0b want 0", busy_a); end
    n_tests++; if (ifa.mem_wr !== 1'b1) begin n_fail++;
      $display("FAIL rmid_wr got %0b want 1", ifa.mem_wr); end
    n_tests++; if (ifa.mem_addr !== 3'd0) begin n_fail++;
      $display("FAIL rmid_addr got %0d want 0", ifa.mem_addr); end
    n_tests++; if (err_a !== 8'd0) begin n_fail++;
      $display("FAIL rmid_err got %0d want 0", err_a); end
    nd = 0;
    for (k = 0; k < 25; k++) begin
      if (done_a) nd++;
      @(negedge clk);
    end
    n_tests++; if (nd !== 0) begin n_fail++;
      $display("FAIL rmid_nodone got %0d want 0", nd); end
    mode_a = 0; start_a = 1'b1;
    wait_done_a(k);
    n_tests++; if (k !== LAT_A) begin n_fail++;
      $display("FAIL rmid_lat got %0d want %0d", k, LAT_A); end
    n_tests++; if (pass_a !== 1'b1) begin n_fail++;
      $display("FAIL rmid_pass got %0b want 1", pass_a); end
    @(negedge clk);
  endtask

  task automatic test_lat3;
    int k;
    logic [7:0] e;
    bit got;
    seed_b = 8'hFE; start_b = 1'b1;
    k = 0; got = 0;
    while (k < 100 && !got) begin
      @(negedge clk);
      k++;
      start_b = 1'b0;
      if (k <= 8) begin
        e = 8'(254 + k - 1);
        n_tests++; if (ifb.mem_wdata !== e) begin n_fail++;
          $display("FAIL lat3_wdata k=%0d got %0h want %0h",
                   k, ifb.mem_wdata, e); end
      end
      if (done_b) got = 1;
    end
    n_tests++; if (k !== LAT_B) begin n_fail++;
      $display("FAIL lat3_lat got %0d want %0d", k, LAT_B); end
    n_tests++; if (pass_b !== 1'b1) begin n_fail++;
      $display("FAIL lat3_pass got %0b want 1", pass_b); end
    n_tests++; if (err_b !== 8'd0) begin n_fail++;
      $display("FAIL lat3_err got %0d want 0", err_b); end
    n_tests++; if (ffa_b !== 3'd0) begin n_fail++;
      $display("FAIL lat3_ffa got %0d want 0", ffa_b); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_corrupt();
    test_stuck();
    test_back_to_back();
    test_rst_mid();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
